// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory lane controller: access sizes,
// controller FSM encoding and the alignment rule.
package dmem_pkg;

    localparam int unsigned SIZE_W = 2;

    localparam logic [SIZE_W-1:0] SIZE_BYTE    = 2'b00;
    localparam logic [SIZE_W-1:0] SIZE_HALF    = 2'b01;
    localparam logic [SIZE_W-1:0] SIZE_WORD    = 2'b10;
    localparam logic [SIZE_W-1:0] SIZE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    // True when an access of this size may start at this byte lane.
    function automatic logic align_ok(input logic [SIZE_W-1:0] size,
                                      input logic [1:0]        addr_lo);
        case (size)
            SIZE_BYTE: return 1'b1;
            SIZE_HALF: return ~addr_lo[0];
            SIZE_WORD: return (addr_lo == 2'b00);
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: store-data replication with byte enables, and
// load lane extraction with sign/zero extension. Purely combinational.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [SIZE_W-1:0] st_size,
    input  logic [1:0]        st_lane,
    input  logic [31:0]       st_data,
    output logic [31:0]       st_lanes_c,
    output logic [3:0]        st_be_c,
    input  logic [SIZE_W-1:0] ld_size,
    input  logic [1:0]        ld_lane,
    input  logic              ld_unsigned,
    input  logic [31:0]       ld_word,
    output logic [31:0]       ld_data_c
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Replicate store data across lanes; the byte enables pick the real target.
    always_comb begin
        st_lanes_c = '0;
        st_be_c    = '0;
        case (st_size)
            SIZE_BYTE: begin
                st_lanes_c = {4{st_data[7:0]}};
                st_be_c    = 4'(4'b0001 << st_lane);
            end
            SIZE_HALF: begin
                st_lanes_c = {2{st_data[15:0]}};
                st_be_c    = st_lane[1] ? 4'b1100 : 4'b0011;
            end
            SIZE_WORD: begin
                st_lanes_c = st_data;
                st_be_c    = 4'b1111;
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte   = ld_word[{ld_lane, 3'b000} +: 8];
        ld_half   = ld_lane[1] ? ld_word[31:16] : ld_word[15:0];
        ld_data_c = '0;
        case (ld_size)
            SIZE_BYTE: ld_data_c = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
            SIZE_HALF: ld_data_c = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
            SIZE_WORD: ld_data_c = ld_word;
            default:   ld_data_c = '0;
        endcase
    end

endmodule

// File: rtl/dmem_lane_ctrl.sv
// Byte-addressed, word-organised data memory with sized/extended accesses,
// alignment checking and a fixed-latency request/ready/response handshake.
module dmem_lane_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned LATENCY       = 1
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     Req,
    input  logic                     Write,
    input  logic [SIZE_W-1:0]        Size,
    input  logic                     Unsigned,
    input  logic [ADDRESS_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0]    WriteData,
    output logic                     Ready,
    output logic                     RespValid,
    output logic [DATA_WIDTH-1:0]    MemData,
    output logic                     AlignErr
);

    localparam int unsigned WORD_AW = ADDRESS_WIDTH - 2;
    localparam int unsigned DEPTH   = 2 ** WORD_AW;
    localparam int unsigned CNT_W   = 4;

    if (DATA_WIDTH != 32) begin : g_bad_data_width
        $error("dmem_lane_ctrl: DATA_WIDTH must be 32");
    end
    if (LATENCY > 15) begin : g_bad_latency
        $error("dmem_lane_ctrl: LATENCY must be 0..15");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept_c;
    logic               err_c;
    logic [WORD_AW-1:0] widx_c;

    logic [SIZE_W-1:0]     size_q;
    logic [1:0]            lane_q;
    logic                  uns_q, write_q, err_q;
    logic [DATA_WIDTH-1:0] rword_q;

    logic [31:0]           st_lanes_c;
    logic [3:0]            st_be_c;
    logic [31:0]           ld_data_c;

    logic                  ready_d, resp_valid_d, align_err_d;
    logic [DATA_WIDTH-1:0] mem_data_d;

    assign accept_c = Req && Ready;
    assign err_c    = ~align_ok(Size, Address[1:0]);
    assign widx_c   = Address[ADDRESS_WIDTH-1:2];

    dmem_lane_align u_align (
        .st_size     (Size),
        .st_lane     (Address[1:0]),
        .st_data     (WriteData),
        .st_lanes_c  (st_lanes_c),
        .st_be_c     (st_be_c),
        .ld_size     (size_q),
        .ld_lane     (lane_q),
        .ld_unsigned (uns_q),
        .ld_word     (rword_q),
        .ld_data_c   (ld_data_c)
    );

    // Array is never reset; stores commit per lane at the accept edge, loads capture the whole word.
    always_ff @(posedge Clk) begin
        if (accept_c && Write && !err_c) begin
            for (int k = 0; k < 4; k++) begin
                if (st_be_c[k]) mem[widx_c][8*k +: 8] <= st_lanes_c[8*k +: 8];
            end
        end
        if (accept_c && !Write) rword_q <= mem[widx_c];
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (LATENCY != 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = RESP;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Response payload is formed in RESP and presented the following cycle.
    always_comb begin
        ready_d      = (state_d == IDLE);
        resp_valid_d = (state_q == RESP);
        mem_data_d   = MemData;
        align_err_d  = AlignErr;
        if (state_q == RESP) begin
            align_err_d = err_q;
            mem_data_d  = (err_q || write_q) ? '0 : DATA_WIDTH'(ld_data_c);
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Ready     <= 1'b1;
            RespValid <= 1'b0;
            MemData   <= '0;
            AlignErr  <= 1'b0;
            size_q    <= SIZE_BYTE;
            lane_q    <= '0;
            uns_q     <= 1'b0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            Ready     <= ready_d;
            RespValid <= resp_valid_d;
            MemData   <= mem_data_d;
            AlignErr  <= align_err_d;
            if (accept_c) begin
                size_q  <= Size;
                lane_q  <= Address[1:0];
                uns_q   <= Unsigned;
                write_q <= Write;
                err_q   <= err_c;
            end
        end
    end

endmodule

// File: tb/tb_dmem_lane_ctrl.sv
// Self-checking bench for dmem_lane_ctrl: vector table through a response
// scoreboard, reset abort, and continuous-request spacing at LATENCY 0 and 15.
module tb_dmem_lane_ctrl;
    import dmem_pkg::*;

    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 32;
    localparam int unsigned LAT = 1;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    logic          rst_n, req, write, uns;
    logic [1:0]    size;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ready, resp_valid, align_err;
    logic [DW-1:0] mem_data;

    logic          h_req, h_write, h_uns;
    logic [1:0]    h_size;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wdata;
    logic          ready0, rv0, ae0, ready15, rv15, ae15;
    logic [DW-1:0] md0, md15;

    dmem_lane_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(LAT)) dut (
        .Clk(Clk), .Rst_n(rst_n), .Req(req), .Write(write), .Size(size),
        .Unsigned(uns), .Address(addr), .WriteData(wdata), .Ready(ready),
        .RespValid(resp_valid), .MemData(mem_data), .AlignErr(align_err)
    );

    dmem_lane_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(0)) dut0 (
        .Clk(Clk), .Rst_n(rst_n), .Req(h_req), .Write(h_write), .Size(h_size),
        .Unsigned(h_uns), .Address(h_addr), .WriteData(h_wdata), .Ready(ready0),
        .RespValid(rv0), .MemData(md0), .AlignErr(ae0)
    );

    dmem_lane_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(15)) dut15 (
        .Clk(Clk), .Rst_n(rst_n), .Req(h_req), .Write(h_write), .Size(h_size),
        .Unsigned(h_uns), .Address(h_addr), .WriteData(h_wdata), .Ready(ready15),
        .RespValid(rv15), .MemData(md15), .AlignErr(ae15)
    );

    typedef struct {
        logic          wr;
        logic [1:0]    sz;
        logic          un;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        logic [DW-1:0] exp_d;
        logic          exp_e;
        string         name;
    } vec_t;

    typedef struct {
        logic [DW-1:0] d;
        logic          e;
        int            acc;
        string         name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic un,
                                input logic [AW-1:0] ad, input logic [DW-1:0] wd,
                                input logic [DW-1:0] exp_d, input logic exp_e,
                                input string name);
        vec_t v;
        v.wr = wr; v.sz = sz; v.un = un; v.ad = ad; v.wd = wd;
        v.exp_d = exp_d; v.exp_e = exp_e; v.name = name;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Present one request; returns just after its accept edge.
    task automatic do_txn(input vec_t v, input logic expect_resp);
        int n;
        @(negedge Clk);
        req = 1'b1; write = v.wr; size = v.sz; uns = v.un; addr = v.ad; wdata = v.wd;
        n = 0;
        while (!ready && n < 50) begin
            @(negedge Clk);
            n++;
        end
        if (!ready) begin
            check({v.name, "_accept_timeout"}, 32'(ready), 32'd1);
            req = 1'b0;
        end else begin
            if (expect_resp) sb.push_back('{d: v.exp_d, e: v.exp_e, acc: cyc + 1, name: v.name});
            @(posedge Clk);
            #1 req = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge Clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        int acc0[$], resp0[$], acc15[$], resp15[$];
        int pulses;

        rst_n = 1'b0; req = 1'b0; write = 1'b0; size = SIZE_WORD; uns = 1'b0;
        addr = '0; wdata = '0;
        h_req = 1'b0; h_write = 1'b1; h_size = SIZE_WORD; h_uns = 1'b0;
        h_addr = 16'h0060; h_wdata = 32'h0F0F_1234;

        vecs.push_back(mk(1, SIZE_WORD, 0, 16'h0010, 32'hDEADBEEF, 32'h0, 0, "sw_10"));
        vecs.push_back(mk(0, SIZE_WORD, 0, 16'h0010, 32'h0,        32'hDEADBEEF, 0, "lw_10"));
        vecs.push_back(mk(1, SIZE_WORD, 0, 16'h0020, 32'h11223344, 32'h0, 0, "sw_20"));
        vecs.push_back(mk(1, SIZE_BYTE, 0, 16'h0021, 32'h123456AA, 32'h0, 0, "sb_21"));
        vecs.push_back(mk(1, SIZE_HALF, 0, 16'h0022, 32'h9999BEEF, 32'h0, 0, "sh_22"));
        vecs.push_back(mk(0, SIZE_WORD, 0, 16'h0020, 32'h0,        32'hBEEFAA44, 0, "lw_20"));
        vecs.push_back(mk(1, SIZE_WORD, 0, 16'h0030, 32'h80FF7F01, 32'h0, 0, "sw_30"));
        vecs.push_back(mk(0, SIZE_BYTE, 0, 16'h0030, 32'h0,        32'h00000001, 0, "lb_30"));
        vecs.push_back(mk(0, SIZE_BYTE, 0, 16'h0032, 32'h0,        32'hFFFFFFFF, 0, "lb_32"));
        vecs.push_back(mk(0, SIZE_BYTE, 1, 16'h0032, 32'h0,        32'h000000FF, 0, "lbu_32"));
        vecs.push_back(mk(0, SIZE_HALF, 0, 16'h0032, 32'h0,        32'hFFFF80FF, 0, "lh_32"));
        vecs.push_back(mk(0, SIZE_HALF, 1, 16'h0032, 32'h0,        32'h000080FF, 0, "lhu_32"));
        vecs.push_back(mk(0, SIZE_HALF, 1, 16'h0030, 32'h0,        32'h00007F01, 0, "lhu_30"));
        vecs.push_back(mk(0, SIZE_BYTE, 0, 16'h0033, 32'h0,        32'hFFFFFF80, 0, "lb_33"));
        vecs.push_back(mk(1, SIZE_WORD, 0, 16'h0040, 32'hCAFEF00D, 32'h0, 0, "sw_40"));
        vecs.push_back(mk(1, SIZE_WORD, 0, 16'h0042, 32'h12345678, 32'h0, 1, "sw_42_misal"));
        vecs.push_back(mk(0, SIZE_HALF, 0, 16'h0031, 32'h0,        32'h0, 1, "lh_31_misal"));
        vecs.push_back(mk(1, SIZE_ILLEGAL, 0, 16'h0040, 32'hFFFFFFFF, 32'h0, 1, "st_size11"));
        vecs.push_back(mk(0, SIZE_ILLEGAL, 0, 16'h0040, 32'h0,     32'h0, 1, "ld_size11"));
        vecs.push_back(mk(0, SIZE_WORD, 0, 16'h0040, 32'h0,        32'hCAFEF00D, 0, "lw_40"));
        vecs.push_back(mk(1, SIZE_WORD, 0, 16'hFFFC, 32'h0BADCAFE, 32'h0, 0, "sw_top"));
        vecs.push_back(mk(0, SIZE_HALF, 1, 16'hFFFE, 32'h0,        32'h00000BAD, 0, "lhu_top"));

        // Response monitor: every RespValid pulse must match the oldest expectation.
        fork
            forever begin
                exp_t e;
                @(negedge Clk);
                if (resp_valid === 1'b1) begin
                    if (sb.size() == 0) begin
                        n_tot++;
                        $display("FAIL unexpected_resp: got RespValid=1 MemData=%h required no response", mem_data);
                    end else begin
                        e = sb.pop_front();
                        check({e.name, "_data"}, mem_data, e.d);
                        check({e.name, "_err"}, 32'(align_err), 32'(e.e));
                        check({e.name, "_lat"}, 32'(cyc - e.acc), 32'(LAT + 1));
                    end
                end
            end
        join_none

        repeat (3) @(negedge Clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_mem_data", mem_data, 32'd0);
        check("rst_align_err", 32'(align_err), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            do_txn(vecs[i], 1'b1);
            wait_drain();
        end

        // Data/error hold after the response cycle.
        repeat (3) @(negedge Clk);
        check("hold_mem_data", mem_data, 32'h00000BAD);
        check("hold_resp_valid", 32'(resp_valid), 32'd0);

        // Abort a store mid-WAIT; its memory write must survive.
        do_txn(mk(1, SIZE_WORD, 0, 16'h0054, 32'h13579BDF, 32'h0, 0, "sw_54_abort"), 1'b0);
        check("pre_abort_ready", 32'(ready), 32'd0);
        rst_n = 1'b0;
        repeat (2) @(negedge Clk);
        rst_n = 1'b1;
        @(negedge Clk);
        check("abort_ready", 32'(ready), 32'd1);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            if (resp_valid === 1'b1) pulses++;
        end
        check("abort_no_resp", 32'(pulses), 32'd0);
        do_txn(mk(0, SIZE_WORD, 0, 16'h0054, 32'h0, 32'h13579BDF, 0, "lw_54_after_rst"), 1'b1);
        wait_drain();

        // Continuous request on the LATENCY=0 and LATENCY=15 instances.
        @(negedge Clk);
        h_req = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (i == 60) h_req = 1'b0;
            if (h_req && ready0)  acc0.push_back(cyc + 1);
            if (h_req && ready15) acc15.push_back(cyc + 1);
            if (rv0)  resp0.push_back(cyc);
            if (rv15) resp15.push_back(cyc);
            @(negedge Clk);
        end
        check("l0_resp_count", 32'(resp0.size()), 32'(acc0.size()));
        check("l15_resp_count", 32'(resp15.size()), 32'(acc15.size()));
        check("l0_accepts", 32'(acc0.size()), 32'd30);
        check("l15_accepts", 32'(acc15.size()), 32'd4);
        for (int k = 1; k < acc0.size(); k++)
            check("l0_spacing", 32'(acc0[k] - acc0[k-1]), 32'd2);
        for (int k = 1; k < acc15.size(); k++)
            check("l15_spacing", 32'(acc15[k] - acc15[k-1]), 32'd17);
        for (int k = 0; k < acc0.size() && k < resp0.size(); k++)
            check("l0_latency", 32'(resp0[k] - acc0[k]), 32'd1);
        for (int k = 0; k < acc15.size() && k < resp15.size(); k++)
            check("l15_latency", 32'(resp15[k] - acc15[k]), 32'd16);
        check("l0_err", 32'(ae0), 32'd0);
        check("l15_store_data", md15, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
